// File: rtl/out_uart_tx.sv
// OUT-instruction back end: buffers 16-bit words in a FIFO and sends each one
// on an 8N1 UART line, low byte first, stalling the pipeline when the FIFO is full.
module out_uart_tx #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        out_en,
    input  logic [15:0] out_dat,
    input  logic        out_adv,
    output logic        out_stall,
    output logic        txd,
    output logic        tx_idle,
    output logic        ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [15:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ovf_r;

    state_t        state_r;
    logic [15:0]   hold_r;
    logic          hi_r;
    logic [2:0]    bit_cnt_r;
    logic [BW-1:0] baud_cnt_r;
    logic          txd_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic baud_done_s;

    // Serial bit for position idx of the currently selected byte of the held word.
    function automatic logic sel_bit(input logic [15:0] w, input logic h, input logic [2:0] idx);
        logic [7:0] b;
        b = h ? w[15:8] : w[7:0];
        return b[idx];
    endfunction

    assign full_s      = (count_r == CW'(DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    assign push_s      = out_en & out_adv & ~full_s;
    assign pop_s       = (state_r == ST_IDLE) & ~empty_s;
    assign baud_done_s = (baud_cnt_r == BW'(CLKS_PER_BIT - 1));

    assign out_stall = out_en & full_s;
    assign tx_idle   = (state_r == ST_IDLE) & empty_s;
    assign txd       = txd_r;
    assign ovf       = ovf_r;

    // FIFO storage write port; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= out_dat;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (out_en && out_adv && full_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Transmit FSM; txd is loaded with the value of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_r     <= 16'h0000;
            hi_r       <= 1'b0;
            bit_cnt_r  <= 3'd0;
            baud_cnt_r <= {BW{1'b0}};
            txd_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= {BW{1'b0}};
                    bit_cnt_r  <= 3'd0;
                    txd_r      <= 1'b1;
                    if (!empty_s) begin
                        hold_r  <= mem_r[rd_ptr_r];
                        hi_r    <= 1'b0;
                        state_r <= ST_START;
                        txd_r   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        bit_cnt_r  <= 3'd0;
                        state_r    <= ST_DATA;
                        txd_r      <= sel_bit(hold_r, hi_r, 3'd0);
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_STOP;
                            txd_r   <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            txd_r     <= sel_bit(hold_r, hi_r, bit_cnt_r + 3'd1);
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        if (!hi_r) begin
                            hi_r    <= 1'b1;
                            state_r <= ST_START;
                            txd_r   <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            txd_r   <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    txd_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_uart_tx.sv
// Directed bench for out_uart_tx (DEPTH=4, CLKS_PER_BIT=4); a line receiver
// decodes txd into bytes so word order and content can be checked.
module tb_out_uart_tx;

    logic        clk;
    logic        reset;
    logic        out_en;
    logic [15:0] out_dat;
    logic        out_adv;
    logic        out_stall;
    logic        txd;
    logic        tx_idle;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rx_q[$];
    int frame_err = 0;

    out_uart_tx #(.DEPTH(4), .CLKS_PER_BIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .out_en    (out_en),
        .out_dat   (out_dat),
        .out_adv   (out_adv),
        .out_stall (out_stall),
        .txd       (txd),
        .tx_idle   (tx_idle),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!tx_idle && n < budget);
        chk(tag, {31'd0, tx_idle}, 32'd1);
    endtask

    function automatic logic [15:0] getw(input int k);
        if (rx_q.size() < 2 * k + 2) return 16'hxxxx;
        return {rx_q[2*k+1], rx_q[2*k]};
    endfunction

    // Line receiver: samples one cycle into each 4-cycle bit; frames cut by reset are dropped.
    initial begin
        logic [7:0] b;
        logic       aborted;
        forever begin
            step();
            if (!reset && txd === 1'b0) begin
                aborted = 1'b0;
                step();
                if (reset) aborted = 1'b1;
                if (txd !== 1'b0 && !aborted) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) begin
                        step();
                        if (reset) aborted = 1'b1;
                    end
                    b[i] = txd;
                end
                repeat (4) begin
                    step();
                    if (reset) aborted = 1'b1;
                end
                if (!aborted) begin
                    if (txd !== 1'b1) frame_err++;
                    rx_q.push_back(b);
                end
            end
        end
    end

    initial begin
        logic [0:19] line;
        logic [15:0] words3 [6];
        int i;
        int guard;
        int first_stall;
        int stall_cycles;
        int low_cnt;

        // 1: reset held 3 cycles
        reset = 1'b1; out_en = 1'b0; out_adv = 1'b0; out_dat = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_stall", {31'd0, out_stall}, 32'd0);
        chk("rst_idle", {31'd0, tx_idle}, 32'd1);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 2: single word 0x12A5, bit-exact line check
        line = 20'b0101001011_0010010001;
        out_en = 1'b1; out_adv = 1'b1; out_dat = 16'h12A5;
        @(negedge clk);
        out_en = 1'b0; out_adv = 1'b0;
        chk("t2_txd_e1", {31'd0, txd}, 32'd1);
        step();
        chk("t2_fall", {31'd0, txd}, 32'd0);
        step();
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t2_bit%0d", k), {31'd0, txd}, {31'd0, line[k]});
            if (k < 19) repeat (4) step();
        end
        repeat (2) step();
        chk("t2_busy_e81", {31'd0, tx_idle}, 32'd0);
        step();
        chk("t2_idle_e82", {31'd0, tx_idle}, 32'd1);
        chk("t2_rxw", {16'd0, getw(0)}, 32'h12A5);
        rx_q.delete();

        // 3: back-to-back 0x0001..0x0006 with out_adv = !out_stall
        for (int k = 0; k < 6; k++) words3[k] = 16'(k + 1);
        i = 0; guard = 0; first_stall = -1; stall_cycles = 0;
        while (i < 6 && guard < 500) begin
            @(negedge clk);
            out_en = 1'b1; out_dat = words3[i];
            #1;
            out_adv = ~out_stall;
            if (out_stall) begin
                stall_cycles++;
                if (first_stall < 0) first_stall = i;
            end
            if (out_adv) i++;
            guard++;
        end
        @(negedge clk);
        out_en = 1'b0; out_adv = 1'b0;
        chk("t3_pushed", i, 6);
        chk("t3_first_stall", first_stall, 5);
        chk("t3_stall_cycles", stall_cycles, 78);
        wait_idle("t3_drain", 1000);
        chk("t3_nbytes", rx_q.size(), 12);
        for (int k = 0; k < 6; k++) chk($sformatf("t3_w%0d", k), {16'd0, getw(k)}, k + 1);
        rx_q.delete();

        // 4: held OUT with out_adv low must not duplicate the word
        @(negedge clk);
        out_en = 1'b1; out_dat = 16'hBEEF; out_adv = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_nostall", {31'd0, out_stall}, 32'd0);
        out_adv = 1'b1;
        @(negedge clk);
        out_en = 1'b0; out_adv = 1'b0;
        wait_idle("t4_drain", 300);
        chk("t4_nbytes", rx_q.size(), 2);
        chk("t4_word", {16'd0, getw(0)}, 32'hBEEF);
        rx_q.delete();

        // 5: forced push while full sets sticky ovf and is dropped
        chk("t5_ovf_pre", {31'd0, ovf}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            out_en = 1'b1; out_adv = 1'b1; out_dat = 16'(16'h1111 * (k + 1));
        end
        @(negedge clk);
        out_dat = 16'hDEAD;
        #1;
        chk("t5_stall_full", {31'd0, out_stall}, 32'd1);
        @(negedge clk);
        out_en = 1'b0; out_adv = 1'b0;
        chk("t5_ovf_set", {31'd0, ovf}, 32'd1);
        wait_idle("t5_drain", 1000);
        chk("t5_ovf_sticky", {31'd0, ovf}, 32'd1);
        chk("t5_nbytes", rx_q.size(), 10);
        for (int k = 0; k < 5; k++) chk($sformatf("t5_w%0d", k), {16'd0, getw(k)}, 32'h1111 * (k + 1));
        chk("t5_frame_err", frame_err, 0);
        rx_q.delete();

        // 6: reset during a DATA bit of 0x00FF with two words queued
        @(negedge clk);
        out_en = 1'b1; out_adv = 1'b1; out_dat = 16'h00FF;
        @(negedge clk);
        out_dat = 16'h0A0A;
        @(negedge clk);
        out_dat = 16'h0B0B;
        @(negedge clk);
        out_en = 1'b0; out_adv = 1'b0;
        repeat (9) @(negedge clk);
        chk("t6_busy", {31'd0, tx_idle}, 32'd0);
        reset = 1'b1;
        step();
        chk("t6_txd", {31'd0, txd}, 32'd1);
        chk("t6_idle", {31'd0, tx_idle}, 32'd1);
        chk("t6_ovf_clr", {31'd0, ovf}, 32'd0);
        chk("t6_stall", {31'd0, out_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        low_cnt = 0;
        repeat (300) begin
            step();
            if (txd !== 1'b1) low_cnt++;
        end
        chk("t6_no_frames", low_cnt, 0);
        chk("t6_rx_empty", rx_q.size(), 0);
        chk("t6_still_idle", {31'd0, tx_idle}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
